// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, frame constants and parity helper for the UART TX scheduler
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } tx_state_t;

  localparam int FRAME_BITS = 11;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the last grant
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_idx,
  output logic             any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    any_req   = |req;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one PISO UART transmitter with gap and watchdog
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               baud_clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               parity_odd,
  output logic               piso_send,
  output logic [7:0]         piso_data,
  output logic               piso_parity,
  input  logic               piso_done,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic [15:0]        frame_count,
  output logic               err_timeout
);

  tx_state_t        state;
  logic [15:0]      wd_cnt;
  logic [15:0]      gap_cnt;
  logic [N_REQ-1:0] grant_oh;
  logic [2:0]       grant_idx;
  logic             any_req;
  logic [7:0]       sel_byte;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .last_grant(grant_id),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  // Accept pulse exists only in the IDLE grant cycle; reset_n keeps it quiet while reset is held.
  assign req_ready = (state == ST_IDLE && reset_n) ? grant_oh : '0;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      piso_send   <= 1'b0;
      piso_data   <= 8'h00;
      piso_parity <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 3'(N_REQ - 1);
      frame_count <= 16'h0000;
      err_timeout <= 1'b0;
      wd_cnt      <= 16'h0000;
      gap_cnt     <= 16'h0000;
    end else begin
      piso_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            piso_data   <= sel_byte;
            piso_parity <= calc_parity(sel_byte, parity_odd);
            grant_id    <= grant_idx;
            piso_send   <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          wd_cnt <= 16'h0000;
          state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Done is checked first so a frame finishing on the timeout cycle still counts.
          if (piso_done || wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            if (piso_done) frame_count <= frame_count + 16'd1;
            else           err_timeout <= 1'b1;
            gap_cnt <= 16'h0000;
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler with a 12-cycle transmitter model
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic          baud_clk;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          parity_odd;
  logic          piso_send;
  logic [7:0]    piso_data;
  logic          piso_parity;
  logic          piso_done;
  logic          busy;
  logic [2:0]    grant_id;
  logic [15:0]   frame_count;
  logic          err_timeout;

  uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .baud_clk   (baud_clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .parity_odd (parity_odd),
    .piso_send  (piso_send),
    .piso_data  (piso_data),
    .piso_parity(piso_parity),
    .piso_done  (piso_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_count(frame_count),
    .err_timeout(err_timeout)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   cd          = 0;
  int   done_cyc    = -1;
  bit   done_en     = 1'b1;
  bit   gap_chk     = 1'b0;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: done pulses 12 cycles after send is sampled; reset abandons the frame.
  always @(negedge baud_clk) begin
    piso_done = 1'b0;
    if (!reset_n) begin
      cd = 0;
    end else if (piso_send) begin
      if (gap_chk && done_cyc >= 0) check("done_to_send_gap", cyc - done_cyc, GAP + 2);
      cd = 12;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && done_en) begin
        piso_done = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  // Scoreboard monitor: every accept pulse is matched against the next expected grant.
  always begin
    exp_t e;
    @(negedge baud_clk);
    if (reset_n && req_ready != '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant: req_ready=%b with empty scoreboard", req_ready);
      end else begin
        e = exp_q.pop_front();
        check("grant_onehot", 32'(req_ready), 32'(1 << e.id));
        @(negedge baud_clk);
        check("piso_data", 32'(piso_data), 32'(e.data));
        check("piso_parity", 32'(piso_parity), 32'(e.par));
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("piso_send_after_grant", 32'(piso_send), 32'd1);
      end
    end
  end

  task automatic drive_edge();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic wait_ready(input int id, input string name);
    int n;
    n = 0;
    do begin
      @(negedge baud_clk);
      n++;
    end while (!req_ready[id] && n < 100);
    check({name, "_ready_seen"}, 32'(req_ready[id]), 32'd1);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge baud_clk);
      n++;
    end
    while (busy && n < 200) begin
      @(negedge baud_clk);
      n++;
    end
    check({name, "_frame_end"}, 32'(n < 200), 32'd1);
  endtask

  task automatic send_one(input int id, input logic [7:0] data, input logic odd,
                          input logic par, input string name);
    drive_edge();
    req_data[8*id +: 8] = data;
    parity_odd          = odd;
    req_valid[id]       = 1'b1;
    exp_q.push_back('{id: id, data: data, par: par});
    wait_ready(id, name);
    drive_edge();
    req_valid[id] = 1'b0;
    wait_frame(name);
  endtask

  task automatic apply_reset();
    drive_edge();
    reset_n   = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge baud_clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int s;
    int n;
    reset_n    = 1'b0;
    req_valid  = 4'b0101;
    req_data   = '0;
    parity_odd = 1'b0;
    piso_done  = 1'b0;
    repeat (3) @(posedge baud_clk);
    @(negedge baud_clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_piso_send", 32'(piso_send), 32'd0);
    check("rst_piso_data", 32'(piso_data), 32'd0);
    check("rst_piso_parity", 32'(piso_parity), 32'd0);
    req_valid = '0;
    drive_edge();
    reset_n = 1'b1;

    // Single request, even parity: 0x55 has four ones.
    send_one(0, 8'h55, 1'b0, 1'b0, "single");
    check("single_frame_count", 32'(frame_count), 32'd1);

    // 0x07 has three ones: odd parity -> 0, even parity -> 1.
    send_one(2, 8'h07, 1'b1, 1'b0, "odd_par");
    send_one(2, 8'h07, 1'b0, 1'b1, "even_par");
    check("par_frame_count", 32'(frame_count), 32'd3);

    // Fairness with all four requesters valid; 0xA0..0xA3 even parity = 0,1,1,0.
    apply_reset();
    drive_edge();
    req_data  = 32'hA3A2A1A0;
    parity_odd = 1'b0;
    done_cyc  = -1;
    gap_chk   = 1'b1;
    exp_q.push_back('{id: 0, data: 8'hA0, par: 1'b0});
    exp_q.push_back('{id: 1, data: 8'hA1, par: 1'b1});
    exp_q.push_back('{id: 2, data: 8'hA2, par: 1'b1});
    exp_q.push_back('{id: 3, data: 8'hA3, par: 1'b0});
    exp_q.push_back('{id: 0, data: 8'hA0, par: 1'b0});
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge baud_clk);
        n++;
      end while (req_ready == '0 && n < 100);
      check("fair_grant_seen", 32'(req_ready != '0), 32'd1);
    end
    drive_edge();
    req_valid = '0;
    wait_frame("fair");
    gap_chk = 1'b0;
    check("fair_frame_count", 32'(frame_count), 32'd5);

    // Watchdog: transmitter never reports done; 0x3C even parity = 0.
    done_en = 1'b0;
    check("wd_err_before", 32'(err_timeout), 32'd0);
    drive_edge();
    req_data[15:8] = 8'h3C;
    req_valid[1]   = 1'b1;
    exp_q.push_back('{id: 1, data: 8'h3C, par: 1'b0});
    wait_ready(1, "wd");
    drive_edge();
    req_valid[1] = 1'b0;
    @(negedge baud_clk);
    s = cyc;
    n = 0;
    while (!err_timeout && n < 60) begin
      @(negedge baud_clk);
      n++;
    end
    // Error appears TO cycles after WAIT_DONE is entered, which is one cycle after the send cycle.
    check("wd_latency", 32'(cyc - s - 1), 32'(TO));
    check("wd_frame_count", 32'(frame_count), 32'd5);
    wait_frame("wd");
    done_en = 1'b1;
    send_one(3, 8'h81, 1'b0, 1'b0, "after_wd");
    check("after_wd_frame_count", 32'(frame_count), 32'd6);
    check("after_wd_err_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of WAIT_DONE; 0x12 and 0x9A both have even parity bit 0.
    drive_edge();
    req_data[7:0] = 8'h12;
    req_valid[0]  = 1'b1;
    exp_q.push_back('{id: 0, data: 8'h12, par: 1'b0});
    wait_ready(0, "midrst");
    drive_edge();
    req_valid[0] = 1'b0;
    repeat (5) @(negedge baud_clk);
    reset_n = 1'b0;
    req_data[7:0]   = 8'h9A;
    req_data[23:16] = 8'h44;
    req_valid       = 4'b0101;
    #1;
    check("midrst_piso_data", 32'(piso_data), 32'd0);
    check("midrst_piso_send", 32'(piso_send), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd3);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check("midrst_err_timeout", 32'(err_timeout), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    exp_q.push_back('{id: 0, data: 8'h9A, par: 1'b0});
    drive_edge();
    reset_n = 1'b1;
    wait_ready(0, "post_rst");
    drive_edge();
    req_valid = '0;
    wait_frame("post_rst");
    check("post_rst_frame_count", 32'(frame_count), 32'd1);

    // Wrap: preload 0xFFFF, one frame later the counter reads 0. 0xFF even parity = 0.
    @(negedge baud_clk);
    force dut.frame_count = 16'hFFFF;
    @(posedge baud_clk);
    #1;
    release dut.frame_count;
    send_one(1, 8'hFF, 1'b0, 1'b0, "wrap");
    check("wrap_frame_count", 32'(frame_count), 32'd0);

    repeat (4) @(negedge baud_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one PISO UART transmitter among N byte requesters using round-robin arbitration.
- Per frame it latches the granted byte, computes the parity bit, pulses the transmitter's send input, and waits for its done flag.
- Enforces an inter-frame idle gap and a watchdog timeout so one hung frame cannot stall the link.
- Sits between the sensor/status message producers and the UART transmitter, all on baud_clk.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, baud_clk cycles of idle line enforced after each frame (0 = back-to-back).
- TIMEOUT_CYCLES, 16, max cycles in WAIT_DONE before abort (must be > 12).

Ports:
- baud_clk  in  1  bit clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  byte for requester i at [8i+7:8i].
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- parity_odd  in  1  0 = even parity, 1 = odd parity; sampled at grant.
- piso_send  out  1  one-cycle start pulse to the transmitter.
- piso_data  out  8  frame byte, held stable from grant through done.
- piso_parity  out  1  parity bit, held with piso_data.
- piso_done  in  1  transmitter frame-complete flag (one cycle).
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- frame_count  out  16  frames completed; wraps 0xFFFF -> 0.
- err_timeout  out  1  sticky; set on watchdog abort, cleared only by reset.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state = IDLE; req_ready = 0; piso_send = 0; piso_data = 0x00; piso_parity = 0.
  - busy = 0; grant_id = N_REQ-1, so requester 0 wins first; frame_count = 0; err_timeout = 0.
  - Any partially sent frame is abandoned; no req_ready pulse is issued.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from (grant_id+1) mod N_REQ upward, with wrap.
  - In that same cycle: req_ready[g] = 1, piso_data <= byte g, grant_id <= g.
  - piso_parity <= ^byte when even, ~^byte when odd.
  - Next state START. With no request, stay in IDLE.
- START: piso_send = 1 for exactly this cycle; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - piso_send = 0; watchdog increments each cycle.
  - On piso_done = 1: frame_count += 1; go to GAP, or to IDLE when GAP_CYCLES = 0.
  - If the watchdog reaches TIMEOUT_CYCLES before done: set err_timeout; frame_count unchanged; go to GAP/IDLE as above.
  - If done and timeout coincide, done wins: count the frame, no error.
- GAP: hold GAP_CYCLES cycles, then go to IDLE. Requests are not accepted during GAP.
- Output timing:
  - req_ready is a Moore-style pulse asserted only in the IDLE grant cycle.
  - The requester sees the accept at the next edge and may then change req_valid/req_data.
- Ignored conditions:
  - A req_valid that drops before it is granted is simply never served.
  - piso_done outside WAIT_DONE is ignored.
- Frame timing:
  - Minimum grant-to-grant period is 2 (IDLE+START) + transmitter frame time + GAP_CYCLES.
  - With the 11-bit frame (start, 8 data LSB-first, parity, stop) the transmitter reports done 12 cycles after sampling send.
- piso_data and piso_parity change only in the IDLE grant cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state enum constants;
  - FRAME_BITS = 11;
  - parity helper function (data, odd) -> bit.
- One sub-module: rr_arbiter (parameter N_REQ; inputs req vector and last-grant pointer; outputs grant one-hot and index plus any_req). Purely combinational; the pointer register lives in uart_tx_scheduler.

Test Plan:
- Single request: req 0 sends 0x55 with even parity -> req_ready[0] pulses once; piso_data = 0x55, piso_parity = 0; piso_send one cycle later; after done, frame_count = 1.
- Odd parity: req 2 sends 0x07 with parity_odd = 1 -> piso_parity = 0; with parity_odd = 0 -> piso_parity = 1.
- Fairness: all 4 valid continuously with bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; each send pulse at least GAP_CYCLES after the previous done.
- Watchdog: piso_done tied low -> err_timeout = 1 exactly TIMEOUT_CYCLES cycles after START; frame_count stays 0; next request is still served.
- Reset mid-frame: assert reset_n = 0 during WAIT_DONE -> all outputs return to reset values immediately; after release req 0 is granted first.
- Wrap: preload frame_count to 0xFFFF and complete one frame -> 0x0000.
